if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage between the PC register and the decode stage.
- Consumes the current PC, issues a request to instruction memory, and computes the next PC fed back to the PC register (PC+4, branch target or jump target; holds the PC when stalled).
- Owns the IF/ID pipeline register.
- Handles variable-latency memory, decode stalls and branch/jump redirects, including a redirect that arrives while a fetch is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on pc_next_o during reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on reset or flush.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pc_i  in  32  current PC from the PC register.
- pc_next_o  out  32  next PC to the PC register input; combinational.
- imem_req_o  out  1  fetch request to instruction memory.
- imem_addr_o  out  32  fetch address; equals pc_i.
- imem_ack_i  in  1  memory returns data this cycle for imem_addr_o.
- imem_data_i  in  32  instruction word, valid when imem_ack_i=1.
- stall_i  in  1  decode hazard; IF/ID must hold.
- branch_i  in  1  taken branch resolved downstream.
- branch_target_i  in  32  branch target.
- jump_i  in  1  jump resolved downstream.
- jump_target_i  in  32  jump target.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_instr_o  out  32  IF/ID instruction.
- ifid_pc4_o  out  32  IF/ID PC+4.

Behaviour:
- Reset, sampled on a clock edge with rst_i=1:
  - State goes to FETCH.
  - ifid_valid_o=0, ifid_instr_o=NOP_INSTR, ifid_pc4_o=0.
  - Hold buffer is invalidated.
  - Saved target is cleared.
  - While rst_i=1: imem_req_o=0 and pc_next_o=RESET_PC.
- Redirect: redir = branch_i | jump_i. Target = branch_target_i if branch_i=1, else jump_target_i (branch wins over jump).
- Redirect priority: redirect > stall > normal flow.
- Arithmetic: pc+4 is 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 = 0. No alignment checks.
- Memory protocol:
  - While imem_req_o=1 and no ack, imem_addr_o must stay stable.
  - pc_next_o=pc_i in that case.
  - A zero-wait memory (ack in the same cycle) gives 1 instruction per cycle.
- FETCH state (imem_req_o=1):
  - redir & ack: IF/ID flushed (valid=0, NOP). pc_next_o=target. Stay in FETCH. Data is discarded.
  - redir & !ack: IF/ID flushed. Target is saved. pc_next_o=pc_i. Go to DRAIN.
  - !redir & ack & !stall: IF/ID <= {1, imem_data_i, pc_i+4}. pc_next_o=pc_i+4.
  - !redir & ack & stall: IF/ID holds. imem_data_i and pc_i+4 go into the hold buffer. pc_next_o=pc_i+4. Go to HOLD.
  - !redir & !ack & stall: IF/ID holds. pc_next_o=pc_i.
  - !redir & !ack & !stall: IF/ID <= bubble (valid=0). pc_next_o=pc_i.
- HOLD state (imem_req_o=0, one buffered instruction):
  - redir: IF/ID flushed. Buffer dropped. pc_next_o=target. Go to FETCH.
  - stall: everything holds. pc_next_o=pc_i.
  - !stall: IF/ID <= buffer. pc_next_o=pc_i. Go to FETCH.
- DRAIN state (imem_req_o=1 on the old address, waiting for the in-flight ack):
  - IF/ID stays a bubble.
  - A further redir overwrites the saved target.
  - On ack: data is discarded, pc_next_o=saved target, go to FETCH.
  - Without ack: pc_next_o=pc_i.
  - stall is ignored.
- Reset mid-operation: any state returns to FETCH, and the in-flight ack is ignored.

Decomposition:
- Shared package: state encoding (FETCH, HOLD, DRAIN), NOP_INSTR, PC_INC=4.
- One natural sub-module: if_id_reg. It is the IF/ID register with load/flush/hold controls and is reusable for later pipeline registers.
- The FSM and next-PC mux stay in if_stage.

Test Plan:
- Zero-wait stream: reset, pc sequence 0 → 4 → 8 with ack=1 every cycle → ifid_pc4_o = 4, 8, 12 on consecutive cycles, valid=1.
- Wait states: ack delayed 2 cycles at pc=0x10 → imem_addr_o stays 0x10, pc_next_o=0x10, IF/ID gets 2 bubbles, then {1, data, 0x14}.
- Stall with ack: stall=1 for 3 cycles when ack arrives at pc=0x20 → IF/ID unchanged, no new req. After stall drops, IF/ID = {1, data, 0x24} and the next fetch address is 0x24.
- Redirect in flight: branch to 0x100 while pc=0x30 is unacked → req held on 0x30, IF/ID bubble. On ack, pc_next_o=0x100 and that data never reaches IF/ID.
- Simultaneous branch, jump and stall: branch_target=0x200, jump_target=0x300 → pc_next_o=0x200, IF/ID flushed.
- Wrap and reset: fetch at 0xFFFF_FFFC → pc_next_o=0. Assert rst_i mid-HOLD → valid=0, instr=NOP, pc_next_o=RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package if_stage_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_word_t;

  // Branch outranks jump when both resolve in the same cycle.
  function automatic logic [31:0] pick_target(input logic        branch,
                                              input logic [31:0] branch_target,
                                              input logic [31:0] jump_target);
    return branch ? branch_target : jump_target;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface if_stage_if;
  import if_stage_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [XLEN-1:0] imem_data_i;

  modport master (output imem_req_o, output imem_addr_o,
                  input  imem_ack_i, input  imem_data_i);
  modport slave  (input  imem_req_o, input  imem_addr_o,
                  output imem_ack_i, output imem_data_i);

endinterface

// File: rtl/if_stage_if_id_reg.sv
// Generic pipeline register with flush > load > hold priority; flushed entries read as NOP.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load,
  input  logic                      flush,
  input  if_stage_pkg::fetch_word_t word,
  output logic                      valid,
  output logic [31:0]               instr,
  output logic [31:0]               pc4
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= 32'd0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      instr <= word.instr;
      pc4   <= word.pc4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: next-PC selection, fetch FSM for variable-latency memory, and the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_stage_pkg::NOP_INSTR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       pc_i,
  output logic [31:0]       pc_next_o,
  if_stage_if.master        imem,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [31:0]       branch_target_i,
  input  logic              jump_i,
  input  logic [31:0]       jump_target_i,
  output logic              ifid_valid_o,
  output logic [31:0]       ifid_instr_o,
  output logic [31:0]       ifid_pc4_o
);
  import if_stage_pkg::*;

  fetch_state_t state;
  fetch_word_t  hold_buf;
  fetch_word_t  load_word;
  logic [31:0]  saved_target;
  logic [31:0]  target;
  logic [31:0]  pc4;
  logic         redir;
  logic         ack;
  logic         load;
  logic         flush;

  assign ack    = imem.imem_ack_i;
  assign redir  = branch_i | jump_i;
  assign target = pick_target(branch_i, branch_target_i, jump_target_i);
  assign pc4    = pc_i + PC_INC;

  // HOLD already owns a fetched word, so no request goes out until it drains into IF/ID.
  assign imem.imem_req_o  = ~rst_i & (state != HOLD);
  assign imem.imem_addr_o = pc_i;

  always_comb begin
    pc_next_o = pc_i;
    if (rst_i) begin
      pc_next_o = RESET_PC;
    end else begin
      case (state)
        FETCH: begin
          if (redir && ack)       pc_next_o = target;
          else if (!redir && ack) pc_next_o = pc4;
        end
        HOLD: begin
          if (redir) pc_next_o = target;
        end
        DRAIN: begin
          // A redirect landing on the same cycle as the ack is newer than the saved one.
          if (ack) pc_next_o = redir ? target : saved_target;
        end
        default: pc_next_o = pc_i;
      endcase
    end
  end

  always_comb begin
    load      = 1'b0;
    flush     = 1'b0;
    load_word = '{instr: imem.imem_data_i, pc4: pc4};
    if (!rst_i) begin
      case (state)
        FETCH: begin
          if (redir)         flush = 1'b1;
          else if (!stall_i) begin
            if (ack) load  = 1'b1;
            else     flush = 1'b1;
          end
        end
        HOLD: begin
          if (redir) flush = 1'b1;
          else if (!stall_i) begin
            load      = 1'b1;
            load_word = hold_buf;
          end
        end
        DRAIN:   flush = 1'b1;
        default: flush = 1'b1;
      endcase
    end
  end

  // Fetch FSM: HOLD parks a word that arrived under stall, DRAIN swallows a squashed in-flight fetch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= FETCH;
      hold_buf     <= '0;
      saved_target <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (redir && !ack) begin
            saved_target <= target;
            state        <= DRAIN;
          end else if (!redir && ack && stall_i) begin
            hold_buf <= '{instr: imem.imem_data_i, pc4: pc4};
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (redir || !stall_i) state <= FETCH;
        end
        DRAIN: begin
          if (redir) saved_target <= target;
          if (ack)   state        <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (load),
    .flush (flush),
    .word  (load_word),
    .valid (ifid_valid_o),
    .instr (ifid_instr_o),
    .pc4   (ifid_pc4_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: per-cycle vector table plus a scoreboard of delivered instructions.
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic [31:0] pc_next_o;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;

  if_stage_if imem_bus ();

  if_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_i            (pc_i),
    .pc_next_o       (pc_next_o),
    .imem            (imem_bus),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .ifid_valid_o    (ifid_valid_o),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_pc4_o      (ifid_pc4_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] data;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        exp_req;
    logic [31:0] exp_next;
    logic        push;
    logic        chk;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] sb[$];
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk_vec(input logic rst, input logic [31:0] pc, input logic ack,
                                  input logic [31:0] data, input logic stall, input logic br,
                                  input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
                                  input logic exp_req, input logic [31:0] exp_next, input logic push,
                                  input logic chk, input logic exp_valid,
                                  input logic [31:0] exp_instr, input logic [31:0] exp_pc4);
    vec_t v;
    v = '{rst: rst, pc: pc, ack: ack, data: data, stall: stall, br: br, bt: bt, jmp: jmp,
          jt: jt, exp_req: exp_req, exp_next: exp_next, push: push, chk: chk,
          exp_valid: exp_valid, exp_instr: exp_instr, exp_pc4: exp_pc4};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_i                = v.rst;
    pc_i                 = v.pc;
    imem_bus.imem_ack_i  = v.ack;
    imem_bus.imem_data_i = v.data;
    stall_i              = v.stall;
    branch_i             = v.br;
    branch_target_i      = v.bt;
    jump_i               = v.jmp;
    jump_target_i        = v.jt;
  endtask

  // One clock: drive at the falling edge, check combinational outputs and decode consumption,
  // then check IF/ID after the rising edge.
  task automatic run_cycle(input vec_t v, input int idx);
    logic [63:0] exp_word;
    applyStimulus(v);
    #1;
    checkOutput($sformatf("req[%0d]", idx), {31'd0, imem_bus.imem_req_o}, {31'd0, v.exp_req});
    checkOutput($sformatf("addr[%0d]", idx), imem_bus.imem_addr_o, v.pc);
    checkOutput($sformatf("pc_next[%0d]", idx), pc_next_o, v.exp_next);
    if (!v.rst && ifid_valid_o && !stall_i) begin
      if (sb.size() == 0) begin
        checkOutput($sformatf("unexpected_instr[%0d]", idx), ifid_instr_o, 32'hxxxx_xxxx);
      end else begin
        exp_word = sb.pop_front();
        checkOutput($sformatf("sb_instr[%0d]", idx), ifid_instr_o, exp_word[63:32]);
        checkOutput($sformatf("sb_pc4[%0d]", idx), ifid_pc4_o, exp_word[31:0]);
      end
    end
    if (v.rst)       sb.delete();
    else if (v.push) sb.push_back({v.data, v.pc + 32'd4});
    @(posedge clk_i);
    @(negedge clk_i);
    if (v.chk) begin
      checkOutput($sformatf("ifid_valid[%0d]", idx), {31'd0, ifid_valid_o}, {31'd0, v.exp_valid});
      checkOutput($sformatf("ifid_instr[%0d]", idx), ifid_instr_o, v.exp_instr);
      if (v.exp_valid || v.rst)
        checkOutput($sformatf("ifid_pc4[%0d]", idx), ifid_pc4_o, v.exp_pc4);
    end
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] word;
    int          lat;

    applyStimulus(mk_vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //                 rst pc            ack data          stl br bt      jmp jt      req next          psh chk v instr         pc4
    tbl.push_back(mk_vec(1, 32'h0,        0, 32'h0,        0, 0, 0,       0, 0,       0, 32'h0,        0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(1, 32'h0,        1, 32'hDEAD_BEEF,0, 0, 0,       0, 0,       0, 32'h0,        0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h0,        1, 32'hA000_0001,0, 0, 0,       0, 0,       1, 32'h4,        1, 1, 1, 32'hA000_0001,32'h4));
    tbl.push_back(mk_vec(0, 32'h4,        1, 32'hA000_0002,0, 0, 0,       0, 0,       1, 32'h8,        1, 1, 1, 32'hA000_0002,32'h8));
    tbl.push_back(mk_vec(0, 32'h8,        1, 32'hA000_0003,0, 0, 0,       0, 0,       1, 32'hC,        1, 1, 1, 32'hA000_0003,32'hC));
    tbl.push_back(mk_vec(0, 32'h10,       0, 32'h0,        0, 0, 0,       0, 0,       1, 32'h10,       0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h10,       0, 32'h0,        0, 0, 0,       0, 0,       1, 32'h10,       0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h10,       1, 32'hB000_0001,0, 0, 0,       0, 0,       1, 32'h14,       1, 1, 1, 32'hB000_0001,32'h14));
    tbl.push_back(mk_vec(0, 32'h20,       1, 32'hC000_0001,1, 0, 0,       0, 0,       1, 32'h24,       1, 1, 1, 32'hB000_0001,32'h14));
    tbl.push_back(mk_vec(0, 32'h24,       0, 32'h0,        1, 0, 0,       0, 0,       0, 32'h24,       0, 1, 1, 32'hB000_0001,32'h14));
    tbl.push_back(mk_vec(0, 32'h24,       0, 32'h0,        1, 0, 0,       0, 0,       0, 32'h24,       0, 1, 1, 32'hB000_0001,32'h14));
    tbl.push_back(mk_vec(0, 32'h24,       0, 32'h0,        0, 0, 0,       0, 0,       0, 32'h24,       0, 1, 1, 32'hC000_0001,32'h24));
    tbl.push_back(mk_vec(0, 32'h24,       1, 32'hD000_0001,0, 0, 0,       0, 0,       1, 32'h28,       1, 1, 1, 32'hD000_0001,32'h28));
    tbl.push_back(mk_vec(0, 32'h30,       0, 32'h0,        0, 1, 32'h100, 0, 0,       1, 32'h30,       0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h30,       0, 32'h0,        1, 0, 0,       0, 0,       1, 32'h30,       0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h30,       1, 32'hE000_0001,0, 0, 0,       0, 0,       1, 32'h100,      0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h100,      1, 32'hF000_0001,0, 0, 0,       0, 0,       1, 32'h104,      1, 1, 1, 32'hF000_0001,32'h104));
    tbl.push_back(mk_vec(0, 32'h104,      0, 32'h0,        0, 0, 0,       0, 0,       1, 32'h104,      0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h104,      1, 32'h9000_0001,1, 1, 32'h200, 1, 32'h300, 1, 32'h200,      0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h200,      0, 32'h0,        0, 0, 0,       1, 32'h300, 1, 32'h200,      0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h200,      0, 32'h0,        0, 1, 32'h340, 0, 0,       1, 32'h200,      0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h200,      1, 32'h8000_0001,0, 0, 0,       0, 0,       1, 32'h340,      0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'hFFFF_FFFC,1, 32'h7000_0001,0, 0, 0,       0, 0,       1, 32'h0,        1, 1, 1, 32'h7000_0001,32'h0));
    tbl.push_back(mk_vec(0, 32'h0,        1, 32'h6000_0001,1, 0, 0,       0, 0,       1, 32'h4,        1, 1, 1, 32'h7000_0001,32'h0));
    tbl.push_back(mk_vec(1, 32'h4,        1, 32'h5000_0001,0, 0, 0,       0, 0,       0, 32'h0,        0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h0,        0, 32'h0,        0, 0, 0,       0, 0,       1, 32'h0,        0, 1, 0, 32'h0,        32'h0));
    tbl.push_back(mk_vec(0, 32'h0,        1, 32'h4000_0001,0, 0, 0,       0, 0,       1, 32'h4,        1, 1, 1, 32'h4000_0001,32'h4));
    tbl.push_back(mk_vec(0, 32'h4,        0, 32'h0,        0, 0, 0,       0, 0,       1, 32'h4,        0, 1, 0, 32'h0,        32'h0));

    @(negedge clk_i);
    for (int i = 0; i < tbl.size(); i++) run_cycle(tbl[i], i);

    // Random-latency memory stream: the address must hold through every wait state.
    pc = 32'h400;
    for (int n = 0; n < 6; n++) begin
      lat  = $urandom_range(0, 2);
      word = 32'h3000_0000 | n;
      for (int w = 0; w < lat; w++)
        run_cycle(mk_vec(0, pc, 0, 32'h0, 0, 0, 0, 0, 0, 1, pc, 0, 1, 0, 32'h0, 32'h0), 100 + n * 4 + w);
      run_cycle(mk_vec(0, pc, 1, word, 0, 0, 0, 0, 0, 1, pc + 32'd4, 1, 1, 1, word, pc + 32'd4),
                100 + n * 4 + 3);
      pc = pc + 32'd4;
    end
    run_cycle(mk_vec(0, pc, 0, 32'h0, 0, 0, 0, 0, 0, 1, pc, 0, 1, 0, 32'h0, 32'h0), 200);

    checkOutput("sb_leftover", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
